// File: rtl/output_buffer_pkg.sv
// Shared configuration for the output buffer: systolic array geometry, tile size,
// FIFO depth and the row type that carries one aligned output row.
package Config;
    localparam int sys_cols      = 4;
    localparam int P_BITWIDTH    = 16;
    localparam int A_rows        = 4;
    localparam int counter_width = 2;
    localparam int OB_DEPTH      = 4;
    localparam int OB_ADDR_W     = $clog2(OB_DEPTH);

    typedef logic [P_BITWIDTH-1:0] psum_t;
    typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] row_t;

    function automatic psum_t relu(input psum_t v);
        return v[P_BITWIDTH-1] ? '0 : v;
    endfunction
endpackage

// File: rtl/output_buffer_fifo.sv
// First-word-fall-through row FIFO (module ob_fifo) with wrap-bit pointers and a
// sticky overflow flag raised when a row arrives with no room and no pop.
module ob_fifo
    import Config::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  wr_en,
    input  logic [sys_cols-1:0][P_BITWIDTH-1:0]   wr_data,
    input  logic                                  rd_ready,
    output logic [sys_cols-1:0][P_BITWIDTH-1:0]   rd_data,
    output logic                                  rd_valid,
    output logic                                  full,
    output logic                                  overflow
);
    row_t               mem [OB_DEPTH];
    logic [OB_ADDR_W:0] wr_ptr;
    logic [OB_ADDR_W:0] rd_ptr;
    logic               empty;
    logic               do_pop;
    logic               do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[OB_ADDR_W] != rd_ptr[OB_ADDR_W]) &&
                      (wr_ptr[OB_ADDR_W-1:0] == rd_ptr[OB_ADDR_W-1:0]);
    assign rd_valid = !empty;
    assign do_pop   = !empty && rd_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign do_push  = wr_en && (!full || do_pop);
    assign rd_data  = empty ? '0 : mem[rd_ptr[OB_ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !do_push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr[OB_ADDR_W-1:0]] <= wr_data;
    end
endmodule

// File: rtl/output_buffer.sv
// Deskews systolic partial sums into rows, queues them in ob_fifo and tags tile ends.
// Define OB_RELU_EN to clamp negative output lanes to zero on the read side.
module output_buffer
    import Config::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  i_valid,
    input  logic [sys_cols-1:0][P_BITWIDTH-1:0]   of_data,
    output logic [sys_cols-1:0][P_BITWIDTH-1:0]   o_data,
    output logic                                  o_valid,
    input  logic                                  o_ready,
    output logic                                  o_last,
    output logic                                  full,
    output logic                                  overflow
);
    localparam logic [counter_width-1:0] LAST_ROW = counter_width'(A_rows - 1);

    logic [P_BITWIDTH-1:0]    aligned [sys_cols];
    row_t                     aligned_row;
    row_t                     fifo_row;
    logic [sys_cols-2:0]      vld_dly;
    logic                     wr_en;
    logic                     transfer;
    logic [counter_width-1:0] row_count;

    // Column c arrives c cycles late, so it needs sys_cols-1-c stages to line up.
    for (genvar c = 0; c < sys_cols; c++) begin : g_col
        localparam int D = sys_cols - 1 - c;
        if (D == 0) begin : g_pass
            assign aligned[c] = of_data[c];
        end else begin : g_dly
            logic [P_BITWIDTH-1:0] stage [D];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst || clr) begin
                    for (int k = 0; k < D; k++)
                        stage[k] <= '0;
                end else begin
                    stage[0] <= of_data[c];
                    for (int k = 1; k < D; k++)
                        stage[k] <= stage[k-1];
                end
            end
            assign aligned[c] = stage[D-1];
        end
    end

    always_comb begin
        aligned_row = '0;
        for (int c = 0; c < sys_cols; c++)
            aligned_row[c] = aligned[c];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_dly <= '0;
        end else if (clr) begin
            vld_dly <= '0;
        end else begin
            vld_dly[0] <= i_valid;
            for (int k = 1; k < sys_cols - 1; k++)
                vld_dly[k] <= vld_dly[k-1];
        end
    end

    assign wr_en = vld_dly[sys_cols-2];

    ob_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_data  (aligned_row),
        .rd_ready (o_ready),
        .rd_data  (fifo_row),
        .rd_valid (o_valid),
        .full     (full),
        .overflow (overflow)
    );

    assign transfer = o_valid && o_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_count <= '0;
        end else if (clr) begin
            row_count <= '0;
        end else if (transfer) begin
            row_count <= (row_count == LAST_ROW) ? '0 : row_count + 1'b1;
        end
    end

    assign o_last = o_valid && (row_count == LAST_ROW);

`ifdef OB_RELU_EN
    always_comb begin
        o_data = '0;
        for (int c = 0; c < sys_cols; c++)
            o_data[c] = relu(fifo_row[c]);
    end
`else
    assign o_data = fifo_row;
`endif
endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based row model.
module tb_output_buffer;
    import Config::*;

    localparam int MAXS = 4096;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic i_valid;
    logic o_ready;
    logic o_valid;
    logic o_last;
    logic full;
    logic overflow;
    row_t of_data;
    row_t o_data;

    output_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .i_valid  (i_valid),
        .of_data  (of_data),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_last   (o_last),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    bit   iss_vld [MAXS];
    row_t iss_row [MAXS];
    row_t model_q[$];
    bit   model_ovf;
    int   model_cnt;
    int   slot;
    int   n_checks;
    int   n_fail;
    bit   check_en;
    bit   last_hist[$];

    function automatic row_t expect_row(input row_t r);
        row_t o;
        o = r;
`ifdef OB_RELU_EN
        for (int c = 0; c < sys_cols; c++)
            if ($signed(r[c]) < 0)
                o[c] = '0;
`endif
        return o;
    endfunction

    function automatic row_t mkrow(input logic [P_BITWIDTH-1:0] base);
        row_t r;
        for (int c = 0; c < sys_cols; c++)
            r[c] = base + P_BITWIDTH'(c);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int c = 0; c < sys_cols; c++)
            r[c] = P_BITWIDTH'($urandom);
        return r;
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b (slot %0d)", name, act, exp, slot);
        end
    endtask

    task automatic checkRow(input string name, input row_t act, input row_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (slot %0d)", name, act, exp, slot);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (slot %0d)", name, act, exp, slot);
        end
    endtask

    task automatic checkOutput();
        bit ev;
        ev = model_q.size() > 0;
        checkBit("o_valid", o_valid, ev);
        checkBit("full", full, model_q.size() == OB_DEPTH);
        checkBit("overflow", overflow, model_ovf);
        checkBit("o_last", o_last, ev && (model_cnt == A_rows - 1));
        if (ev)
            checkRow("o_data", o_data, expect_row(model_q[0]));
        if (o_valid === 1'b1 && o_ready === 1'b1)
            last_hist.push_back(o_last);
    endtask

    always @(negedge clk) begin
        if (check_en)
            checkOutput();
    end

    // Row-level model: a row issued in slot s lands in the queue at the edge ending slot s+sys_cols-1.
    task automatic modelEdge(input bit rdy, input bit cl);
        bit pop;
        bit wr;
        int src;
        src = slot - (sys_cols - 1);
        pop = (model_q.size() > 0) && rdy;
        wr  = (src >= 0) && iss_vld[src];
        if (cl) begin
            model_q.delete();
            model_ovf = 0;
            model_cnt = 0;
            for (int k = slot - sys_cols; k <= slot; k++)
                if (k >= 0)
                    iss_vld[k] = 0;
        end else begin
            if (pop) begin
                void'(model_q.pop_front());
                model_cnt = (model_cnt == A_rows - 1) ? 0 : model_cnt + 1;
            end
            if (wr) begin
                if (model_q.size() == OB_DEPTH)
                    model_ovf = 1;
                else
                    model_q.push_back(iss_row[src]);
            end
        end
    endtask

    task automatic applyStimulus(input bit iv, input row_t r, input bit rdy, input bit cl);
        iss_vld[slot] = iv;
        iss_row[slot] = r;
        i_valid = iv;
        o_ready = rdy;
        clr     = cl;
        for (int c = 0; c < sys_cols; c++) begin
            if (slot - c >= 0 && iss_vld[slot - c])
                of_data[c] = iss_row[slot - c][c];
            else
                of_data[c] = P_BITWIDTH'($urandom);
        end
        @(posedge clk);
        modelEdge(rdy, cl);
        #1;
        slot++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, rand_row(), rdy, 1'b0);
    endtask

    task automatic applyReset();
        check_en = 0;
        i_valid  = 0;
        clr      = 0;
        o_ready  = 0;
        rst      = 0;
        #1;
        checkBit("async reset o_valid", o_valid, 1'b0);
        checkBit("async reset full", full, 1'b0);
        checkBit("async reset overflow", overflow, 1'b0);
        checkBit("async reset o_last", o_last, 1'b0);
        checkRow("async reset o_data", o_data, '0);
        model_q.delete();
        model_ovf = 0;
        model_cnt = 0;
        for (int k = slot - sys_cols; k <= slot; k++)
            if (k >= 0)
                iss_vld[k] = 0;
        @(posedge clk);
        #1;
        rst = 1;
        slot++;
        check_en = 1;
    endtask

    function automatic int hist_mask();
        int m;
        m = 0;
        for (int i = 0; i < last_hist.size(); i++)
            if (last_hist[i])
                m |= (1 << i);
        return m;
    endfunction

    initial begin
        rst = 0; clr = 0; i_valid = 0; o_ready = 0; of_data = '0;
        slot = 0; check_en = 0; n_checks = 0; n_fail = 0;
        model_ovf = 0; model_cnt = 0;
        #12;
        checkBit("reset o_valid", o_valid, 1'b0);
        checkBit("reset full", full, 1'b0);
        checkBit("reset overflow", overflow, 1'b0);
        checkBit("reset o_last", o_last, 1'b0);
        checkRow("reset o_data", o_data, '0);
        @(posedge clk);
        #1;
        rst = 1;
        check_en = 1;

        // Single row: visible exactly sys_cols-1 edges after i_valid is sampled.
        idle(2, 1'b1);
        applyStimulus(1'b1, mkrow(16'h0100), 1'b1, 1'b0);
        idle(2, 1'b1);
        checkBit("latency early", o_valid, 1'b0);
        idle(1, 1'b1);
        checkBit("latency o_valid", o_valid, 1'b1);
        checkRow("latency o_data", o_data, 64'h0103_0102_0101_0100);
        idle(1, 1'b1);
        checkBit("single transfer done", o_valid, 1'b0);

        // Fill to full with backpressure, then one extra row overflows.
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, mkrow(16'h1000 + 16'(k * 16)), 1'b0, 1'b0);
        idle(2, 1'b0);
        checkBit("full after 4 rows", full, 1'b1);
        checkBit("no overflow at 4 rows", overflow, 1'b0);
        idle(1, 1'b0);
        checkBit("overflow on 5th row", overflow, 1'b1);
        checkRow("head kept after overflow", o_data, expect_row(64'h1003_1002_1001_1000));

        // Flush, then write and pop together while full.
        applyStimulus(1'b0, rand_row(), 1'b0, 1'b1);
        checkBit("clr o_valid", o_valid, 1'b0);
        checkBit("clr full", full, 1'b0);
        checkBit("clr overflow", overflow, 1'b0);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, mkrow(16'h2000 + 16'(k * 16)), 1'b0, 1'b0);
        idle(2, 1'b0);
        checkBit("full before pop+write", full, 1'b1);
        applyStimulus(1'b0, rand_row(), 1'b1, 1'b0);
        checkBit("pop+write no overflow", overflow, 1'b0);
        checkBit("pop+write still full", full, 1'b1);
        checkRow("pop+write head", o_data, expect_row(64'h2013_2012_2011_2010));
        idle(6, 1'b1);

        // Eight streamed rows: o_last on the 4th and 8th transfers.
        applyStimulus(1'b0, rand_row(), 1'b1, 1'b1);
        last_hist.delete();
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, mkrow(16'h3000 + 16'(k * 16)), 1'b1, 1'b0);
        idle(6, 1'b1);
        checkInt("transfers of 8 rows", last_hist.size(), 8);
        checkInt("o_last pattern 8 rows", hist_mask(), 32'h88);

        // Signed lanes: negative values are clamped only when ReLU is built in.
        applyStimulus(1'b1, {16'h7FFF, 16'h8000, 16'h00FF, 16'hFF00}, 1'b0, 1'b0);
        idle(3, 1'b0);
`ifdef OB_RELU_EN
        checkRow("relu lanes", o_data, 64'h7FFF_0000_00FF_0000);
`else
        checkRow("raw lanes", o_data, 64'h7FFF_8000_00FF_FF00);
`endif
        idle(2, 1'b1);

        // Mid-tile reset with two rows queued; the next tile restarts at row 0.
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, mkrow(16'h4000 + 16'(k * 16)), 1'b0, 1'b0);
        idle(3, 1'b0);
        applyStimulus(1'b0, rand_row(), 1'b1, 1'b0);
        checkBit("two rows queued", o_valid, 1'b1);
        applyReset();
        last_hist.delete();
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, mkrow(16'h5000 + 16'(k * 16)), 1'b1, 1'b0);
        idle(6, 1'b1);
        checkInt("transfers after reset", last_hist.size(), 4);
        checkInt("o_last pattern after reset", hist_mask(), 32'h8);

        // Random traffic with backpressure and occasional flushes.
        for (int i = 0; i < 700; i++)
            applyStimulus(1'($urandom_range(0, 1)), rand_row(),
                          $urandom_range(0, 99) < 60, $urandom_range(0, 99) == 0);
        idle(8, 1'b1);

        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
- REQ-001: clk  input  1  sole clock; all state updates on posedge clk.
- REQ-002: rst  input  1  asynchronous, active-low reset.
- REQ-003: clr  input  1  synchronous flush; clears FIFO, row counter, delay lines and overflow flag.
- REQ-004: i_valid  input  1  column-0 result of one output row is present on of_data[0] this cycle.
- REQ-005: of_data  input  [sys_cols][P_BITWIDTH]  skewed systolic partial sums; column c lags column 0 by c cycles.
- REQ-006: o_data  output  [sys_cols][P_BITWIDTH]  aligned output row at FIFO head.
- REQ-007: o_valid  output  1  o_data holds a valid row.
- REQ-008: o_ready  input  1  consumer accepts the row; transfer occurs when o_valid && o_ready.
- REQ-009: o_last  output  1  qualifies the row with index A_rows-1 of the current tile.
- REQ-010: full  output  1  FIFO holds OB_DEPTH rows; the controller stalls on it.
- REQ-011: overflow  output  1  sticky flag; an aligned row was dropped.

Function
- REQ-012: Deskew: column c delayed by (sys_cols-1-c) registers; i_valid delayed by sys_cols-1 registers to form aligned write-enable.
- REQ-013: Aligned row written to FIFO (depth OB_DEPTH, first-word-fall-through) on the cycle its delayed valid is high.
- REQ-014: Latency: i_valid sampled at edge t, FIFO empty -> o_valid high after edge t+sys_cols-1 with correct row; no bubbles for back-to-back i_valid.
- REQ-015: Deskew pipeline never stalls; backpressure acts only via full.
- REQ-016: Write while full and no pop same cycle -> row dropped, FIFO unchanged, overflow set until rst or clr.
- REQ-017: Write and pop same cycle while full -> both succeed, occupancy unchanged, no overflow.
- REQ-018: Pop while empty impossible (o_valid low); o_ready ignored.
- REQ-019: Row counter (counter_width bits) increments on each transfer; o_last = o_valid && count == A_rows-1; counter wraps to 0 after that transfer.
- REQ-020: o_data held stable while o_valid && !o_ready.
- REQ-021: clr wins over simultaneous write and pop; next cycle o_valid=0, full=0.
- REQ-022: Pointers of log2(OB_DEPTH)+1 bits; full/empty derived from MSB comparison.

Reset
- REQ-023: rst low asynchronously forces o_valid=0, full=0, overflow=0, o_last=0, o_data=0, pointers, counter and delay lines to 0.
- REQ-024: rst deassertion mid-tile discards all in-flight rows; the first i_valid afterwards is row 0.

Configuration
- REQ-025: Macro OB_RELU_EN defined -> each o_data lane is 0 when its signed value is negative, otherwise unchanged; combinational on FIFO read side, no added latency.
- REQ-026: OB_RELU_EN undefined -> o_data is the raw signed FIFO contents.

Structure
- REQ-027: OB_DEPTH (power of two) and the existing sys_cols, P_BITWIDTH, A_rows and counter_width live in package Config.
- REQ-028: FIFO storage and pointers in sub-module ob_fifo, instantiated once; deskew, counter and ReLU in output_buffer.

Verification (sys_cols=4, P_BITWIDTH=16, OB_DEPTH=4, A_rows=4)
- REQ-029: One i_valid at cycle 10, column c driving 0x0100+c at cycle 10+c, o_ready=1 -> o_valid at cycle 13, o_data={0x0103,0x0102,0x0101,0x0100}, transfer completes at cycle 13.
- REQ-030: Four back-to-back rows, o_ready=0 -> full=1 after the 4th write; a 5th row -> overflow=1 and FIFO contents unchanged.
- REQ-031: Full FIFO, o_ready=1, and a new row arriving the same cycle -> no overflow; rows popped in order.
- REQ-032: Eight rows streamed out -> o_last high on the 4th and 8th transfers only.
- REQ-033: OB_RELU_EN defined, column value 0xFF00 -> output 0x0000; column value 0x00FF -> output 0x00FF. Undefined -> 0xFF00 passes through.
- REQ-034: rst pulsed low mid-tile with 2 rows queued -> outputs 0 immediately; the next row after release carries o_last only at count 3.
